// File: rtl/pwr_ctrl_pkg.sv
// Shared types for the power-gating sequencer:
// state enum, state_o encodings and timer sizing.
package pwr_ctrl_pkg;

  localparam logic [3:0] ST_ON       = 4'd0;
  localparam logic [3:0] ST_CLK_STOP = 4'd1;
  localparam logic [3:0] ST_ISO_ON   = 4'd2;
  localparam logic [3:0] ST_SAVE     = 4'd3;
  localparam logic [3:0] ST_PD_WAIT  = 4'd4;
  localparam logic [3:0] ST_OFF      = 4'd5;
  localparam logic [3:0] ST_PU_WAIT  = 4'd6;
  localparam logic [3:0] ST_RESTORE  = 4'd7;
  localparam logic [3:0] ST_ISO_OFF  = 4'd8;
  localparam logic [3:0] ST_CLK_ON   = 4'd9;

  typedef enum logic [3:0] {
    S_ON       = ST_ON,
    S_CLK_STOP = ST_CLK_STOP,
    S_ISO_ON   = ST_ISO_ON,
    S_SAVE     = ST_SAVE,
    S_PD_WAIT  = ST_PD_WAIT,
    S_OFF      = ST_OFF,
    S_PU_WAIT  = ST_PU_WAIT,
    S_RESTORE  = ST_RESTORE,
    S_ISO_OFF  = ST_ISO_OFF,
    S_CLK_ON   = ST_CLK_ON
  } pwr_state_e;

  function automatic int cnt_w(int a, int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pwr_gate_controller_timer.sv
// Loadable down-counter shared by the settle
// and acknowledge-timeout waits.
module pwr_seq_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/pwr_gate_controller.sv
// Power-switch sequencer: clock stop, isolate, save,
// power off, and the mirror sequence back up.
module pwr_gate_controller
  import pwr_ctrl_pkg::*;
#(
  parameter int SETTLE      = 2,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sleep_req,
  input  logic       wake_req,
  input  logic       pwr_ack,
  input  logic       err_clr,
  output logic       power_enable,
  output logic       clk_en,
  output logic       iso_en,
  output logic       save,
  output logic       restore,
  output logic       busy,
  output logic       domain_on,
  output logic       timeout_err,
  output logic [3:0] state_o
);

  localparam int TW = cnt_w(SETTLE, ACK_TIMEOUT);
  localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE - 1);
  localparam logic [TW-1:0] ACK_LD    = TW'(ACK_TIMEOUT - 1);

  pwr_state_e    state;
  pwr_state_e    next;
  logic          done;
  logic          load;
  logic          tmo;
  logic [TW-1:0] load_val;

  logic pe_d;
  logic ce_d;
  logic iso_d;
  logic save_d;
  logic rest_d;
  logic busy_d;
  logic on_d;

  pwr_seq_timer #(
    .W(TW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .done     (done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_ON;
    end else begin
      state <= next;
    end
  end

  always_comb begin
    next = state;
    tmo  = 1'b0;
    unique case (state)
      S_ON: begin
        if (sleep_req && !wake_req) next = S_CLK_STOP;
      end
      S_CLK_STOP: begin
        if (done) next = S_ISO_ON;
      end
      S_ISO_ON: begin
        if (done) next = S_SAVE;
      end
      S_SAVE: next = S_PD_WAIT;
      S_PD_WAIT: begin
        if (!pwr_ack) begin
          next = S_OFF;
        end else if (done) begin
          next = S_OFF;
          tmo  = 1'b1;
        end
      end
      S_OFF: begin
        if (wake_req) next = S_PU_WAIT;
      end
      S_PU_WAIT: begin
        if (pwr_ack) begin
          next = S_RESTORE;
        end else if (done) begin
          next = S_RESTORE;
          tmo  = 1'b1;
        end
      end
      S_RESTORE: next = S_ISO_OFF;
      S_ISO_OFF: begin
        if (done) next = S_CLK_ON;
      end
      S_CLK_ON: next = S_ON;
      default:  next = S_ON;
    endcase
  end

  // Timer is reloaded on every state entry
  always_comb begin
    load     = (next != state);
    load_val = SETTLE_LD;
    if (next == S_PD_WAIT || next == S_PU_WAIT) begin
      load_val = ACK_LD;
    end
  end

  // Domain controls follow the state one cycle later
  always_comb begin
    pe_d   = !(state inside {S_PD_WAIT, S_OFF});
    ce_d   = state inside {S_ON, S_CLK_ON};
    iso_d  = state inside {S_ISO_ON, S_SAVE, S_PD_WAIT,
                           S_OFF, S_PU_WAIT, S_RESTORE};
    save_d = (state == S_SAVE);
    rest_d = (state == S_RESTORE);
    busy_d = !(next inside {S_ON, S_OFF});
    on_d   = (next == S_ON);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      power_enable <= 1'b1;
      clk_en       <= 1'b1;
      iso_en       <= 1'b0;
      save         <= 1'b0;
      restore      <= 1'b0;
      busy         <= 1'b0;
      domain_on    <= 1'b1;
      timeout_err  <= 1'b0;
    end else begin
      power_enable <= pe_d;
      clk_en       <= ce_d;
      iso_en       <= iso_d;
      save         <= save_d;
      restore      <= rest_d;
      busy         <= busy_d;
      domain_on    <= on_d;
      if (tmo) begin
        timeout_err <= 1'b1;
      end else if (err_clr) begin
        timeout_err <= 1'b0;
      end
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_pwr_gate_controller.sv
// Randomized scoreboard bench for pwr_gate_controller
// with a timeline reference model and a lagging switch.
module tb_pwr_gate_controller;
  import pwr_ctrl_pkg::*;

  localparam int SET = 2;
  localparam int TMO = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sleep_req = 1'b0;
  logic       wake_req = 1'b0;
  logic       pwr_ack = 1'b1;
  logic       err_clr = 1'b0;
  logic       power_enable;
  logic       clk_en;
  logic       iso_en;
  logic       save;
  logic       restore;
  logic       busy;
  logic       domain_on;
  logic       timeout_err;
  logic [3:0] state_o;

  pwr_gate_controller #(
    .SETTLE      (SET),
    .ACK_TIMEOUT (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sleep_req    (sleep_req),
    .wake_req     (wake_req),
    .pwr_ack      (pwr_ack),
    .err_clr      (err_clr),
    .power_enable (power_enable),
    .clk_en       (clk_en),
    .iso_en       (iso_en),
    .save         (save),
    .restore      (restore),
    .busy         (busy),
    .domain_on    (domain_on),
    .timeout_err  (timeout_err),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic pe;
    logic ce;
    logic iso;
    logic sv;
    logic rs;
    logic busy;
    logic dom;
    logic err;
  } obs_t;

  typedef enum {M_ON, M_OFF, M_DN, M_UP} mk_e;

  obs_t expq[$];
  int   n_chk = 0;
  int   n_fail = 0;

  int   dly = 3;
  bit   stuck1 = 1'b0;
  bit   stuck0 = 1'b0;

  mk_e  kind = M_ON;
  int   st = 0;
  int   e_off = 0;
  int   cyc = 0;
  bit   seq_err = 1'b0;
  bit   m_err = 1'b0;

  // Switch cell: rail follows the enable D cycles later
  initial begin
    logic [15:0] hist;
    hist = '1;
    forever begin
      @(negedge clk);
      hist = {hist[14:0], power_enable};
      if (stuck1) pwr_ack = 1'b1;
      else if (stuck0) pwr_ack = 1'b0;
      else pwr_ack = hist[dly];
    end
  end

  function automatic obs_t exp_out(mk_e kd, int k, int e);
    obs_t o;
    o = '0;
    case (kd)
      M_ON: begin
        o.st = ST_ON; o.pe = 1'b1;
        o.ce = 1'b1;  o.dom = 1'b1;
      end
      M_OFF: begin
        o.st = ST_OFF; o.iso = 1'b1;
      end
      M_DN: begin
        if (k < SET) o.st = ST_CLK_STOP;
        else if (k < 2*SET) o.st = ST_ISO_ON;
        else if (k == 2*SET) o.st = ST_SAVE;
        else o.st = ST_PD_WAIT;
        o.ce   = (k < 1);
        o.iso  = (k > SET);
        o.sv   = (k == 2*SET + 1);
        o.pe   = (k < 2*SET + 2);
        o.busy = 1'b1;
      end
      default: begin
        if (k < e) o.st = ST_PU_WAIT;
        else if (k == e) o.st = ST_RESTORE;
        else if (k <= e + SET) o.st = ST_ISO_OFF;
        else o.st = ST_CLK_ON;
        o.pe   = (k >= 1);
        o.iso  = (k <= e + 1);
        o.rs   = (k == e + 1);
        o.busy = 1'b1;
      end
    endcase
    return o;
  endfunction

  // Reference model: each sequence is a timeline from its start edge
  initial begin
    obs_t x;
    int   k;
    bit   t;
    forever begin
      @(posedge clk);
      cyc++;
      k = cyc - st;
      t = 1'b0;
      if (rst) begin
        kind = M_ON;
        st = cyc;
        m_err = 1'b0;
      end else begin
        if (kind == M_ON && sleep_req && !wake_req) begin
          kind = M_DN;
          st = cyc;
          seq_err = stuck1;
          e_off = stuck1 ? 2*SET + 1 + TMO : 2*SET + 3 + dly;
        end else if (kind == M_OFF && wake_req) begin
          kind = M_UP;
          st = cyc;
          seq_err = stuck0;
          e_off = stuck0 ? TMO : 2 + dly;
        end else if (kind == M_DN && k == e_off) begin
          kind = M_OFF;
          t = seq_err;
        end else if (kind == M_UP && k == e_off) begin
          t = seq_err;
        end else if (kind == M_UP && k == e_off + SET + 2) begin
          kind = M_ON;
        end
        if (t) m_err = 1'b1;
        else if (err_clr) m_err = 1'b0;
      end
      x = exp_out(kind, cyc - st, e_off);
      x.err = m_err;
      expq.push_back(x);
    end
  end

  // Monitor: one observation per cycle, away from the edge
  initial begin
    obs_t w;
    obs_t a;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        w = expq.pop_front();
        a = {state_o, power_enable, clk_en, iso_en, save,
             restore, busy, domain_on, timeout_err};
        n_chk++;
        if (a !== w) begin
          n_fail++;
          $display({"FAIL outputs cyc=%0d got st=%0d pe=%b ce=%b",
                    " iso=%b sv=%b rs=%b busy=%b on=%b err=%b",
                    " want st=%0d pe=%b ce=%b iso=%b sv=%b rs=%b",
                    " busy=%b on=%b err=%b"},
                   cyc, a.st, a.pe, a.ce, a.iso, a.sv, a.rs,
                   a.busy, a.dom, a.err, w.st, w.pe, w.ce,
                   w.iso, w.sv, w.rs, w.busy, w.dom, w.err);
        end
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic bound_fail(string what);
    n_chk++;
    n_fail++;
    $display("FAIL %s wait expired at cyc=%0d", what, cyc);
  endtask

  task automatic wait_steady();
    int b;
    b = 0;
    while (!(kind == M_ON || kind == M_OFF)) begin
      tick();
      b++;
      if (b > 200) begin
        bound_fail("steady");
        break;
      end
    end
  endtask

  task automatic wait_dn(int off);
    int b;
    b = 0;
    while (!(kind == M_DN && cyc - st == off)) begin
      tick();
      b++;
      if (b > 200) begin
        bound_fail("dn_offset");
        break;
      end
    end
  endtask

  task automatic pulse_sleep();
    sleep_req = 1'b1; tick(); sleep_req = 1'b0;
  endtask

  task automatic pulse_wake();
    wake_req = 1'b1; tick(); wake_req = 1'b0;
  endtask

  initial begin
    int r;
    tick(3);
    rst = 1'b0;
    tick(5);
    // basic down / up
    pulse_sleep();
    wait_steady(); tick(4);
    pulse_wake();
    wait_steady(); tick(4);
    // both requests in ON
    sleep_req = 1'b1; wake_req = 1'b1; tick(4);
    sleep_req = 1'b0; wake_req = 1'b0; tick(2);
    // wake toggled during ISO_ON
    pulse_sleep(); tick(SET + 1);
    pulse_wake(); tick();
    wait_steady(); tick(4);
    pulse_wake(); wait_steady(); tick(4);
    // stuck rail during power-down, then clear
    stuck1 = 1'b1;
    pulse_sleep(); wait_steady(); tick(2);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    stuck1 = 1'b0; tick(10);
    pulse_wake(); wait_steady(); tick(4);
    // clear coinciding with a new timeout
    stuck1 = 1'b1;
    pulse_sleep();
    wait_dn(e_off - 1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    wait_steady(); stuck1 = 1'b0; tick(10);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    pulse_wake(); wait_steady(); tick(4);
    // reset during PD_WAIT
    pulse_sleep();
    wait_dn(2*SET + 2);
    rst = 1'b1; tick(); rst = 1'b0; tick(10);

    for (int i = 0; i < 60; i++) begin
      wait_steady();
      r = $urandom_range(0, 7);
      case (r)
        0: begin
          dly = $urandom_range(0, 5);
          tick(8);
        end
        1, 2: begin
          sleep_req = 1'($urandom_range(0, 1));
          wake_req  = 1'($urandom_range(0, 1));
          tick($urandom_range(1, 4));
          for (int j = 0; j < 6; j++) begin
            wake_req  = 1'($urandom_range(0, 1));
            sleep_req = 1'($urandom_range(0, 1));
            tick();
          end
          sleep_req = 1'b0; wake_req = 1'b0;
          tick();
        end
        3: begin
          err_clr = 1'b1; tick(); err_clr = 1'b0;
        end
        4: begin
          if (kind == M_ON) begin
            stuck1 = 1'b1;
            pulse_sleep(); wait_steady();
            stuck1 = 1'b0; tick(8);
          end
        end
        5: begin
          if (kind == M_OFF) begin
            stuck0 = 1'b1;
            pulse_wake(); wait_steady();
            stuck0 = 1'b0; tick(8);
          end
        end
        6: begin
          if (kind == M_ON) pulse_sleep();
          else pulse_wake();
          tick($urandom_range(1, 12));
          rst = 1'b1; tick(); rst = 1'b0;
          tick(8);
        end
        default: tick($urandom_range(1, 5));
      endcase
    end
    wait_steady();
    tick(4);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
